hex_seg_decoder: RTL and testbench
==================================

Name: hex_seg_decoder

Overview:
- Decoder side of the 7-segment hex display path: turns HEX-style segment patterns back into 4-bit nibbles.
- Receives a time-multiplexed stream of (digit index, segment pattern) beats, for example from a display bus monitor or a scan-chain capture of HEX0..HEX5.
- Assembles a full frame of digits and presents it with a valid/ready handshake.
- Used in self-check benches and on-board loopback to read displayed ALU operands and results back as binary.

Parameters:
- NUM_DIGITS, 6, digits per frame (1..8); digit i occupies data_out[4i+3:4i].
- ACTIVE_LOW, 1, 1 = segments lit when 0 (board HEX polarity); 0 = incoming pattern is inverted before decode.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment pattern, bit0 = segment a .. bit6 = segment g.
- digit_sel  input  3  digit index of the current beat.
- seg_valid  input  1  beat qualifier, one beat per cycle.
- seg_ready  output  1  high when a beat will be accepted.
- data_out  output  4*NUM_DIGITS  assembled nibbles, registered.
- err_out  output  NUM_DIGITS  per-digit undecodable-pattern flags.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts frame.
- overrun  output  1  sticky; a beat was offered while seg_ready=0 or digit_sel>=NUM_DIGITS.

Behaviour:
- Decode table, active-low g..a:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
  - Any other pattern decodes to nibble 0 and sets that digit's err bit.
- Reset:
  - data_out=0, err_out=0, out_valid=0, overrun=0, received mask=0.
  - State=COLLECT, seg_ready=1.
  - Reset mid-frame discards any partial frame.
- FSM has two states: COLLECT and HOLD.
- COLLECT:
  - seg_ready=1.
  - On seg_valid with digit_sel<NUM_DIGITS: write the nibble and err bit for that digit, and set its mask bit.
  - A repeated index overwrites the earlier value (last write wins) and does not complete the frame early.
  - When the mask becomes all-ones, the next state is HOLD and out_valid rises on the following edge. Latency: last beat accepted at edge N gives out_valid=1 after edge N.
- HOLD:
  - seg_ready=0; out_valid=1.
  - data_out and err_out are stable until the handshake.
  - out_valid && out_ready at an edge: clear the mask and return to COLLECT; data_out keeps its old value until overwritten.
  - A seg_valid in HOLD is dropped and sets overrun.
- digit_sel>=NUM_DIGITS with seg_valid (either state): beat dropped, overrun set, mask unchanged.
- Handshake-and-beat edge: a seg_valid in the same cycle as the HOLD→COLLECT handshake is still dropped, because seg_ready was 0 in that cycle.
- overrun clears only on reset.
- data_out and err_out update only on accepted beats; no combinational path from seg_in to outputs.

Optional Feature:
- HEX_SEG_BLANK_EN defined:
  - Pattern 7F (all segments off) is legal: nibble 0, err bit 0.
  - Adds output blank_out[NUM_DIGITS-1:0]: per-digit blank flag, reset 0, updated with that digit's nibble.
- Not defined: 7F is undecodable (err bit set) and blank_out does not exist.

Test Plan:
- Reset, then beats for digits 0..5 with patterns 79,24,30,19,12,02 (one per cycle), out_ready=0 → out_valid=1 one edge after the 6th beat; data_out=654321; err_out=0; stays held.
- While in HOLD, offer digit 0 with 40 → seg_ready=0, beat dropped, overrun=1, data_out unchanged; then out_ready=1 → out_valid falls next edge, seg_ready=1.
- Frame with digit 3 = 7F and digit 5 = 55, others 40 → data_out=000000, err_out=101000b (macro off); with HEX_SEG_BLANK_EN defined, err_out=100000b and blank_out=001000b.
- Digit 2 sent as 08 then 0E before the remaining digits → data_out[11:8]=F; out_valid only after all 6 distinct indices.
- digit_sel=6 with seg_valid → overrun=1, mask unchanged, no out_valid.
- Assert reset after 4 beats, then send 6 fresh beats of 18 → out_valid after the 6th beat only; data_out=999999.

Source files
------------

// File: rtl/hex_seg_decoder_if.sv
// Beat and frame channels for hex_seg_decoder.
// HEX_SEG_BLANK_EN adds the per-digit blank_out flags.
interface hex_seg_decoder_if #(
   parameter int NUM_DIGITS = 6
);
   // Both channels are valid/ready: a transfer happens only at a rising clock
   // edge where valid and ready are both high. The producer holds its payload
   // stable while valid is high and ready is low; ready may not depend on valid.
   logic [6:0]              seg_in;
   logic [2:0]              digit_sel;
   logic                    seg_valid;
   logic                    seg_ready;
   logic [4*NUM_DIGITS-1:0] data_out;
   logic [NUM_DIGITS-1:0]   err_out;
   logic                    out_valid;
   logic                    out_ready;
   logic                    overrun;
`ifdef HEX_SEG_BLANK_EN
   logic [NUM_DIGITS-1:0]   blank_out;
`endif

   modport master (
      output seg_in, digit_sel, seg_valid, out_ready,
      input  seg_ready, data_out, err_out, out_valid, overrun
`ifdef HEX_SEG_BLANK_EN
      , input blank_out
`endif
   );

   modport slave (
      input  seg_in, digit_sel, seg_valid, out_ready,
      output seg_ready, data_out, err_out, out_valid, overrun
`ifdef HEX_SEG_BLANK_EN
      , output blank_out
`endif
   );
endinterface

// File: rtl/hex_seg_decoder.sv
// Collects (digit, segment pattern) beats into a frame of decoded hex nibbles.
// Optional feature macro HEX_SEG_BLANK_EN: all-off pattern is a legal blank digit.
module hex_seg_decoder #(
   parameter int NUM_DIGITS = 6,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   hex_seg_decoder_if.slave    bus,
   output logic                state_dbg
);
   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   state_t                  state, state_next;
   logic [NUM_DIGITS-1:0]   mask;
   logic [NUM_DIGITS-1:0]   sel_bit;
   logic [4*NUM_DIGITS-1:0] data_q;
   logic [NUM_DIGITS-1:0]   err_q;
   logic                    overrun_q;
   logic                    in_range;
   logic                    accept;
   logic                    handshake;
   logic [6:0]              pat;
   logic [4:0]              dec;

   // Returns {err, nibble}; patterns are active-low g..a.
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'h40: decode = 5'h00;
         7'h79: decode = 5'h01;
         7'h24: decode = 5'h02;
         7'h30: decode = 5'h03;
         7'h19: decode = 5'h04;
         7'h12: decode = 5'h05;
         7'h02: decode = 5'h06;
         7'h78: decode = 5'h07;
         7'h00: decode = 5'h08;
         7'h18: decode = 5'h09;
         7'h08: decode = 5'h0A;
         7'h03: decode = 5'h0B;
         7'h46: decode = 5'h0C;
         7'h21: decode = 5'h0D;
         7'h06: decode = 5'h0E;
         7'h0E: decode = 5'h0F;
`ifdef HEX_SEG_BLANK_EN
         7'h7F: decode = 5'h00;
`endif
         default: decode = 5'h10;
      endcase
   endfunction

   assign pat       = ACTIVE_LOW ? bus.seg_in : ~bus.seg_in;
   assign dec       = decode(pat);
   assign in_range  = 32'(bus.digit_sel) < NUM_DIGITS;
   assign accept    = bus.seg_valid && (state == COLLECT) && in_range;
   assign handshake = (state == HOLD) && bus.out_ready;

   always_comb begin
      sel_bit = '0;
      for (int d = 0; d < NUM_DIGITS; d++)
         if (bus.digit_sel == 3'(d)) sel_bit[d] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= COLLECT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         COLLECT: if (accept && ((mask | sel_bit) == {NUM_DIGITS{1'b1}})) state_next = HOLD;
         HOLD:    if (bus.out_ready) state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
   end

   always_comb begin
      bus.seg_ready = (state == COLLECT);
      bus.out_valid = (state == HOLD);
      state_dbg     = state;
   end

`ifdef HEX_SEG_BLANK_EN
   logic [NUM_DIGITS-1:0] blank_q;
   assign bus.blank_out = blank_q;
`endif

   // Dropped beats (HOLD or out-of-range index) mark overrun; it stays set until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q    <= '0;
         err_q     <= '0;
         mask      <= '0;
         overrun_q <= 1'b0;
`ifdef HEX_SEG_BLANK_EN
         blank_q   <= '0;
`endif
      end else begin
         if (bus.seg_valid && !accept) overrun_q <= 1'b1;
         if (handshake) mask <= '0;
         for (int d = 0; d < NUM_DIGITS; d++) begin
            if (accept && sel_bit[d]) begin
               data_q[4*d +: 4] <= dec[3:0];
               err_q[d]         <= dec[4];
               mask[d]          <= 1'b1;
`ifdef HEX_SEG_BLANK_EN
               blank_q[d]       <= (pat == 7'h7F);
`endif
            end
         end
      end
   end

   assign bus.data_out = data_q;
   assign bus.err_out  = err_q;
   assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_hex_seg_decoder.sv
// Directed bench for hex_seg_decoder: frames are checked by a monitor against
// an expected queue of {blank, err, data} words; control signals checked inline.
module tb_hex_seg_decoder;
   logic        clk;
   logic        reset;
   logic        state_dbg;
   int          checks;
   int          errors;
   logic        prev_valid;
   logic [35:0] exp_q[$];

   hex_seg_decoder_if #(.NUM_DIGITS(6)) bus ();

   hex_seg_decoder #(.NUM_DIGITS(6), .ACTIVE_LOW(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      reset         = 1'b1;
      bus.seg_valid = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // driver tasks
   task automatic beat(input logic [2:0] sel, input logic [6:0] seg);
      bus.digit_sel = sel;
      bus.seg_in    = seg;
      bus.seg_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.seg_valid = 1'b0;
   endtask

   task automatic take_frame();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [35:0] frame(input logic [23:0] d, input logic [5:0] e,
                                         input logic [5:0] b);
      frame = {b, e, d};
   endfunction

   // scoreboard monitor: compares each newly presented frame
   always @(negedge clk) begin
      logic [5:0] act_blank;
`ifdef HEX_SEG_BLANK_EN
      act_blank = bus.blank_out;
`else
      act_blank = 6'b0;
`endif
      if (!reset && bus.out_valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %h expected none",
                     {act_blank, bus.err_out, bus.data_out});
         end else begin
            check("frame", {act_blank, bus.err_out, bus.data_out}, exp_q.pop_front());
         end
      end
      prev_valid = bus.out_valid;
   end

   initial begin
      logic [6:0] pat_a[6];
      logic [6:0] pat_b[6];
      logic [6:0] pat_c[6];
      checks        = 0;
      errors        = 0;
      prev_valid    = 1'b0;
      bus.seg_in    = 7'h7F;
      bus.digit_sel = 3'd0;
      bus.seg_valid = 1'b0;
      bus.out_ready = 1'b0;
      reset         = 1'b1;
      pat_a = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
      pat_b = '{7'h40, 7'h40, 7'h40, 7'h7F, 7'h40, 7'h55};
      pat_c = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h00};
      do_reset();

      check("rst_data",      36'(bus.data_out), 36'h0);
      check("rst_err",       36'(bus.err_out), 36'h0);
      check("rst_out_valid", 36'(bus.out_valid), 36'h0);
      check("rst_overrun",   36'(bus.overrun), 36'h0);
      check("rst_seg_ready", 36'(bus.seg_ready), 36'h1);
      check("rst_state",     36'(state_dbg), 36'h0);

      // digits 1..6 one per cycle, held with out_ready low
      exp_q.push_back(frame(24'h654321, 6'h00, 6'h00));
      for (int i = 0; i < 6; i++) begin
         if (i == 5) check("no_valid_before_last", 36'(bus.out_valid), 36'h0);
         beat(3'(i), pat_a[i]);
      end
      check("valid_after_last", 36'(bus.out_valid), 36'h1);
      idle(3);
      check("valid_held",  36'(bus.out_valid), 36'h1);
      check("data_held",   36'(bus.data_out), 36'h654321);
      check("hold_ready",  36'(bus.seg_ready), 36'h0);

      // beat offered in HOLD is dropped
      beat(3'd0, 7'h40);
      check("hold_overrun", 36'(bus.overrun), 36'h1);
      check("hold_data",    36'(bus.data_out), 36'h654321);
      take_frame();
      check("release_valid", 36'(bus.out_valid), 36'h0);
      check("release_ready", 36'(bus.seg_ready), 36'h1);

      // blank and illegal digits
`ifdef HEX_SEG_BLANK_EN
      exp_q.push_back(frame(24'h000000, 6'b100000, 6'b001000));
`else
      exp_q.push_back(frame(24'h000000, 6'b101000, 6'b000000));
`endif
      for (int i = 0; i < 6; i++) beat(3'(i), pat_b[i]);
      check("blank_frame_valid", 36'(bus.out_valid), 36'h1);
      take_frame();

      // letters A..E and 8
      exp_q.push_back(frame(24'h8EDCBA, 6'h00, 6'h00));
      for (int i = 0; i < 6; i++) beat(3'(i), pat_c[i]);
      take_frame();

      // repeated index: last write wins, no early completion
      exp_q.push_back(frame(24'h543F10, 6'h00, 6'h00));
      beat(3'd2, 7'h08);
      beat(3'd2, 7'h0E);
      beat(3'd0, 7'h40);
      beat(3'd1, 7'h79);
      beat(3'd3, 7'h30);
      beat(3'd4, 7'h19);
      check("repeat_no_early", 36'(bus.out_valid), 36'h0);
      beat(3'd5, 7'h12);
      check("repeat_valid", 36'(bus.out_valid), 36'h1);
      check("repeat_digit2", 36'(bus.data_out[11:8]), 36'hF);
      take_frame();

      // out-of-range index
      do_reset();
      check("reset_clears_overrun", 36'(bus.overrun), 36'h0);
      beat(3'd6, 7'h40);
      check("range_overrun", 36'(bus.overrun), 36'h1);
      check("range_no_valid", 36'(bus.out_valid), 36'h0);
      for (int i = 0; i < 5; i++) beat(3'(i), 7'h78);
      check("range_mask_unchanged", 36'(bus.out_valid), 36'h0);
      check("range_data", 36'(bus.data_out), 36'h077777);

      // reset mid-frame, then a fresh frame of nines
      do_reset();
      for (int i = 0; i < 4; i++) beat(3'(i), 7'h18);
      do_reset();
      check("midreset_data", 36'(bus.data_out), 36'h0);
      exp_q.push_back(frame(24'h999999, 6'h00, 6'h00));
      for (int i = 0; i < 6; i++) begin
         if (i == 5) check("nines_no_early", 36'(bus.out_valid), 36'h1 - 36'h1);
         beat(3'(i), 7'h18);
      end
      check("nines_valid", 36'(bus.out_valid), 36'h1);
      idle(2);
      take_frame();
      idle(2);

      check("exp_q_empty", 36'(exp_q.size()), 36'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
